control_unit: RTL and testbench

//  Fetch/decode/execute sequencer for the 8-bit CPU. It fetches instructions over an imem handshake, decodes them and drives the ALU opcode.
//  It also drives the register-file selects and write strobes, and latches the ALU zero flag for conditional jumps.

---
 rtl/cpu_pkg.sv | 42 ++++
 rtl/control_unit_program_counter.sv | 42 ++++
 rtl/control_unit.sv | 194 +++++++++++++++++++
 tb/tb_control_unit.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: opcodes, control FSM state encoding
// and instruction field positions. Imported by control_unit, the ALU and the bench.
// Instruction byte layout: {op[7:5], rd[4:3], rs[2:1], unused[0]}.
package cpu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_LDI = 3'b011;
  localparam logic [2:0] OP_JZ  = 3'b100;
  localparam logic [2:0] OP_JMP = 3'b101;
  localparam logic [2:0] OP_NOP = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  localparam int IR_OP_HI = 7;
  localparam int IR_OP_LO = 5;
  localparam int IR_RD_HI = 4;
  localparam int IR_RD_LO = 3;
  localparam int IR_RS_HI = 2;
  localparam int IR_RS_LO = 1;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXEC      = 3'd2,
    ST_FETCH_IMM = 3'd3,
    ST_HALT      = 3'd4
  } state_t;

  function automatic logic [2:0] ir_op(input logic [7:0] ir);
    return ir[IR_OP_HI:IR_OP_LO];
  endfunction

  function automatic logic [1:0] ir_rd(input logic [7:0] ir);
    return ir[IR_RD_HI:IR_RD_LO];
  endfunction

  function automatic logic [1:0] ir_rs(input logic [7:0] ir);
    return ir[IR_RS_HI:IR_RS_LO];
  endfunction

endpackage

// File: rtl/control_unit_program_counter.sv
// program_counter: PC register for the control unit.
// Ports:
//   clk, rst   - clock, synchronous active-high reset (loads PC_RESET)
//   load       - load load_val (has priority over inc)
//   inc        - increment by one, wrapping modulo 2**ADDR_W
//   load_val   - jump target
//   pc         - current PC
module program_counter #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_val;
    end else if (inc) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= PC_RESET;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/control_unit.sv
// control_unit: fetch/decode/execute sequencer for the 8-bit CPU.
// Fetches instruction and immediate bytes over a req/ack handshake, drives the
// ALU opcode and register-file selects/strobes, and latches the ALU zero flag
// on every ALU instruction for use by JZ.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   imem_req/addr/ack/data - instruction memory handshake (req held until ack)
//   alu_op, zf_in        - ALU opcode out, combinational zero flag in
//   rf_raddr_a/b         - register-file read selects
//   rf_we/waddr/wsel     - one-cycle write strobe, target, source (1 = imm)
//   imm                  - immediate byte for LDI writes
//   halted               - high while in HALT
//   step                 - only with CTRL_SINGLE_STEP_EN: one instruction per pulse
// Optional feature macro: CTRL_SINGLE_STEP_EN.
module control_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
  input  logic              clk,
  input  logic              rst,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic              step,
`endif
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [7:0]        imem_data,
  output logic [2:0]        alu_op,
  input  logic              zf_in,
  output logic [1:0]        rf_raddr_a,
  output logic [1:0]        rf_raddr_b,
  output logic              rf_we,
  output logic [1:0]        rf_waddr,
  output logic              rf_wsel,
  output logic [7:0]        imm,
  output logic              halted
);

  state_t            state_q, state_d;
  logic [7:0]        ir_q, ir_d;
  logic              zf_q, zf_d;
  logic [ADDR_W-1:0] pc;
  logic              pc_load;
  logic              pc_inc;
  logic              fetch_go;
  logic              fetch_done;
  logic              unused_ir_bit;

  assign unused_ir_bit = ir_q[0];

  program_counter #(
    .ADDR_W  (ADDR_W),
    .PC_RESET(PC_RESET)
  ) u_pc (
    .clk     (clk),
    .rst     (rst),
    .load    (pc_load),
    .inc     (pc_inc),
    .load_val(ADDR_W'(imem_data)),
    .pc      (pc)
  );

`ifdef CTRL_SINGLE_STEP_EN
  // A step pulse is remembered until the instruction fetch it released completes.
  logic step_seen_q, step_seen_d;

  assign fetch_go    = step_seen_q;
  assign step_seen_d = (step_seen_q & ~fetch_done) | step;

  always_ff @(posedge clk) begin
    if (rst) begin
      step_seen_q <= 1'b0;
    end else begin
      step_seen_q <= step_seen_d;
    end
  end
`else
  assign fetch_go = 1'b1;
`endif

  assign fetch_done = (state_q == ST_FETCH) && fetch_go && imem_ack;

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    zf_d       = zf_q;
    pc_load    = 1'b0;
    pc_inc     = 1'b0;
    imem_req   = 1'b0;
    imem_addr  = '0;
    alu_op     = OP_ADD;
    rf_raddr_a = 2'd0;
    rf_raddr_b = 2'd0;
    rf_we      = 1'b0;
    rf_waddr   = 2'd0;
    rf_wsel    = 1'b0;
    imm        = 8'h00;
    halted     = 1'b0;

    unique case (state_q)
      ST_FETCH: begin
        if (fetch_go) begin
          imem_req  = 1'b1;
          imem_addr = pc;
          if (imem_ack) begin
            ir_d    = imem_data;
            pc_inc  = 1'b1;
            state_d = ST_DECODE;
          end
        end
      end

      ST_DECODE: begin
        unique case (ir_op(ir_q))
          OP_ADD, OP_AND, OP_NOT: state_d = ST_EXEC;
          OP_LDI, OP_JZ, OP_JMP:  state_d = ST_FETCH_IMM;
          OP_NOP:                 state_d = ST_FETCH;
          default:                state_d = ST_HALT;
        endcase
      end

      ST_EXEC: begin
        alu_op     = ir_op(ir_q);
        rf_raddr_a = ir_rd(ir_q);
        rf_raddr_b = ir_rs(ir_q);
        rf_we      = 1'b1;
        rf_waddr   = ir_rd(ir_q);
        zf_d       = zf_in;
        state_d    = ST_FETCH;
      end

      ST_FETCH_IMM: begin
        imem_req  = 1'b1;
        imem_addr = pc;
        if (imem_ack) begin
          state_d = ST_FETCH;
          if (ir_op(ir_q) == OP_LDI) begin
            rf_we    = 1'b1;
            rf_wsel  = 1'b1;
            rf_waddr = ir_rd(ir_q);
            imm      = imem_data;
            pc_inc   = 1'b1;
          end else if (ir_op(ir_q) == OP_JMP) begin
            pc_load = 1'b1;
          end else begin
            // JZ: taken loads the target, not taken skips the target byte
            pc_load = zf_q;
            pc_inc  = ~zf_q;
          end
        end
      end

      ST_HALT: begin
        halted = 1'b1;
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase

    // Reset silences every output in the same cycle so no stray request or
    // write escapes while the registers are being reloaded.
    if (rst) begin
      pc_load    = 1'b0;
      pc_inc     = 1'b0;
      imem_req   = 1'b0;
      imem_addr  = '0;
      alu_op     = OP_ADD;
      rf_raddr_a = 2'd0;
      rf_raddr_b = 2'd0;
      rf_we      = 1'b0;
      rf_waddr   = 2'd0;
      rf_wsel    = 1'b0;
      imm        = 8'h00;
      halted     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      ir_q    <= 8'h00;
      zf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      zf_q    <= zf_d;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack;
  logic [7:0] imem_data;
  logic [2:0] alu_op;
  logic       zf_in;
  logic [1:0] rf_raddr_a;
  logic [1:0] rf_raddr_b;
  logic       rf_we;
  logic [1:0] rf_waddr;
  logic       rf_wsel;
  logic [7:0] imm;
  logic       halted;

  always #5 clk = ~clk;

  control_unit #(
    .ADDR_W  (8),
    .PC_RESET(8'h00)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .alu_op    (alu_op),
    .zf_in     (zf_in),
    .rf_raddr_a(rf_raddr_a),
    .rf_raddr_b(rf_raddr_b),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wsel   (rf_wsel),
    .imm       (imm),
    .halted    (halted)
  );

  // Environment: instruction memory, register file and ALU around the DUT
  logic [7:0] mem [256];
  logic [7:0] env_rf [4];
  logic [7:0] alu_y;

  function automatic logic [7:0] alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a & b;
      3'b010:  return ~a;
      default: return 8'h00;
    endcase
  endfunction

  assign alu_y = alu(alu_op, env_rf[rf_raddr_a], env_rf[rf_raddr_b]);
  assign zf_in = (alu_y == 8'h00);

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) env_rf[i] <= 8'h00;
    end else if (rf_we) begin
      env_rf[rf_waddr] <= rf_wsel ? imm : alu_y;
    end
  end

  // Scoreboard
  localparam int EV_FETCH = 0;
  localparam int EV_WRITE = 1;
  localparam int EV_HALT  = 2;
  typedef struct {
    int kind;
    int a;
    int b;
  } ev_t;
  ev_t expq[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic expect_ev(input int kind, input int a, input int b, input string nm);
    ev_t e;
    if (expq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: unexpected event a=%0h b=%0h, scoreboard empty (t=%0t)", nm, a, b, $time);
    end else begin
      e = expq.pop_front();
      chk({nm, "_kind"}, kind, e.kind);
      chk({nm, "_a"}, a, e.a);
      chk({nm, "_b"}, b, e.b);
    end
  endtask

  // Reference model: instruction-set level interpreter over mem, starting from
  // the reset state, producing the ordered trace of fetches, writes and halt.
  task automatic build_expect();
    int         pc;
    bit         zf;
    int         r [4];
    logic [7:0] ir;
    logic [7:0] y;
    int         op, rd, rs;
    expq.delete();
    pc = 0;
    zf = 1'b0;
    for (int i = 0; i < 4; i++) r[i] = 0;
    for (int n = 0; n < 1000; n++) begin
      ir = mem[pc];
      expq.push_back('{EV_FETCH, pc, 0});
      pc = (pc + 1) % 256;
      op = int'(ir) / 32;
      rd = (int'(ir) / 8) % 4;
      rs = (int'(ir) / 2) % 4;
      if (op <= 2) begin
        y     = alu(3'(op), 8'(r[rd]), 8'(r[rs]));
        zf    = (y == 8'h00);
        r[rd] = int'(y);
        expq.push_back('{EV_WRITE, rd, int'(y)});
      end else if (op == 3) begin
        expq.push_back('{EV_FETCH, pc, 0});
        r[rd] = int'(mem[pc]);
        expq.push_back('{EV_WRITE, rd, r[rd]});
        pc = (pc + 1) % 256;
      end else if (op == 4) begin
        expq.push_back('{EV_FETCH, pc, 0});
        pc = zf ? int'(mem[pc]) : (pc + 1) % 256;
      end else if (op == 5) begin
        expq.push_back('{EV_FETCH, pc, 0});
        pc = int'(mem[pc]);
      end else if (op == 7) begin
        expq.push_back('{EV_HALT, 0, 0});
        break;
      end
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'hE0;
  endtask

  // Random loop-free program: jumps only target later instruction starts.
  task automatic gen_random(input int len);
    int         starts[$];
    int         jpos[$];
    int         cands[$];
    int         p;
    logic [2:0] op;
    logic [1:0] rd, rs;
    logic       u;
    clear_mem();
    p = 0;
    while (p < len) begin
      op = 3'($urandom_range(0, 6));
      rd = 2'($urandom_range(0, 3));
      rs = 2'($urandom_range(0, 3));
      u  = 1'($urandom_range(0, 1));
      if ((op == OP_LDI || op == OP_JZ || op == OP_JMP) && p + 1 >= len) op = OP_NOP;
      starts.push_back(p);
      mem[p] = {op, rd, rs, u};
      if (op == OP_LDI) mem[p+1] = 8'($urandom_range(0, 255));
      if (op == OP_JZ || op == OP_JMP) jpos.push_back(p);
      p += (op == OP_LDI || op == OP_JZ || op == OP_JMP) ? 2 : 1;
    end
    starts.push_back(p);
    foreach (jpos[j]) begin
      cands.delete();
      foreach (starts[s]) if (starts[s] > jpos[j]) cands.push_back(starts[s]);
      mem[jpos[j] + 1] = 8'(cands[$urandom_range(0, cands.size() - 1)]);
    end
  endtask

  // imem responder: random wait, optional forced ack, optional blocked address
  int max_wait   = 0;
  bit ack_force  = 1'b0;
  int block_addr = -1;

  initial begin
    bit active;
    int wcnt;
    active    = 1'b0;
    wcnt      = 0;
    imem_ack  = 1'b0;
    imem_data = 8'h00;
    forever begin
      @(posedge clk);
      #2;
      if (ack_force) begin
        imem_ack  = 1'b1;
        imem_data = mem[0];
      end else if (!imem_req) begin
        active    = 1'b0;
        imem_ack  = 1'b0;
        imem_data = 8'($urandom_range(0, 255));
      end else if (int'(imem_addr) == block_addr) begin
        imem_ack  = 1'b0;
        imem_data = 8'($urandom_range(0, 255));
      end else begin
        if (!active) begin
          active = 1'b1;
          wcnt   = int'($urandom_range(0, max_wait));
        end
        if (wcnt == 0) begin
          imem_ack  = 1'b1;
          imem_data = mem[imem_addr];
          active    = 1'b0;
        end else begin
          wcnt--;
          imem_ack  = 1'b0;
          imem_data = 8'($urandom_range(0, 255));
        end
      end
    end
  end

  // Monitor
  bit         mon_pend      = 1'b0;
  logic [7:0] mon_pend_addr = 8'h00;
  bit         mon_hprev     = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_pend  = 1'b0;
        mon_hprev = 1'b0;
      end else begin
        if (mon_pend) begin
          chk("req_hold", imem_req, 1);
          chk("addr_hold", imem_addr, mon_pend_addr);
        end
        if (imem_req && imem_ack) expect_ev(EV_FETCH, imem_addr, 0, "fetch");
        if (rf_we) expect_ev(EV_WRITE, rf_waddr, rf_wsel ? imm : alu_y, "write");
        if (halted && !mon_hprev) expect_ev(EV_HALT, 0, 0, "halt");
        if (halted) begin
          chk("halt_req", imem_req, 0);
          chk("halt_we", rf_we, 0);
        end
        mon_pend      = imem_req && !imem_ack;
        mon_pend_addr = imem_addr;
        mon_hprev     = halted;
      end
    end
  end

  task automatic restart();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    build_expect();
    #1 rst = 1'b0;
  endtask

  task automatic wait_halt(input string nm, output int cycles);
    int n;
    n = 0;
    while (!halted && n < 4000) begin
      @(negedge clk);
      n++;
    end
    cycles = n;
    if (!halted) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: halted=%0d after %0d cycles, expected 1", nm, halted, n);
    end else begin
      repeat (20) @(negedge clk);
      chk({nm, "_halted_stays"}, halted, 1);
      chk({nm, "_sb_empty"}, expq.size(), 0);
    end
  endtask

  initial begin
    int cyc;
    rst       = 1'b1;
    ack_force = 1'b1;

    // Reset with ack held high, then LDI/LDI/ADD/JZ taken
    clear_mem();
    mem[8'h00] = 8'h68;  // LDI r1
    mem[8'h01] = 8'h05;
    mem[8'h02] = 8'h70;  // LDI r2
    mem[8'h03] = 8'hFB;
    mem[8'h04] = 8'h0C;  // ADD r1,r2
    mem[8'h05] = 8'h80;  // JZ 40
    mem[8'h06] = 8'h40;
    repeat (2) begin
      @(negedge clk);
      chk("rst_req", imem_req, 0);
      chk("rst_addr", imem_addr, 0);
      chk("rst_we", rf_we, 0);
      chk("rst_halted", halted, 0);
    end
    @(posedge clk);
    build_expect();
    #1;
    rst       = 1'b0;
    ack_force = 1'b0;
    @(negedge clk);
    chk("post_rst_req", imem_req, 1);
    chk("post_rst_addr", imem_addr, 0);
    wait_halt("ldi_add_jz", cyc);
    chk("ldi_add_jz_latency", cyc + 1, 15);
    chk("r1_sum", env_rf[1], 8'h00);
    chk("r2_imm", env_rf[2], 8'hFB);

    // JZ not taken, JMP FF, ADD at FF, wrap to 00, JZ taken
    clear_mem();
    mem[8'h00] = 8'h80;  // JZ 06
    mem[8'h01] = 8'h06;
    mem[8'h02] = 8'h60;  // LDI r0,00
    mem[8'h03] = 8'h00;
    mem[8'h04] = 8'hA0;  // JMP FF
    mem[8'h05] = 8'hFF;
    mem[8'hFF] = 8'h00;  // ADD r0,r0
    restart();
    wait_halt("wrap", cyc);

    // Random programs with random imem wait states
    max_wait = 5;
    for (int k = 0; k < 8; k++) begin
      gen_random(40);
      restart();
      wait_halt("random", cyc);
    end

    // Reset while the immediate fetch is stalled
    max_wait = 2;
    clear_mem();
    mem[8'h00] = 8'h68;  // LDI r1,5A
    mem[8'h01] = 8'h5A;
    block_addr = 1;
    restart();
    cyc = 0;
    while (!(imem_req && imem_addr == 8'h01) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("stall_reached", (imem_req && imem_addr == 8'h01) ? 1 : 0, 1);
    repeat (4) @(negedge clk);
    chk("stall_no_write", rf_we, 0);
    block_addr = -1;
    restart();
    @(negedge clk);
    chk("restart_req", imem_req, 1);
    chk("restart_addr", imem_addr, 0);
    wait_halt("restart", cyc);
    chk("restart_r1", env_rf[1], 8'h5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
